// File: rtl/div_issue_pkg.sv
// div_issue_pkg: shared definitions for the divider issue logic.
//   RegBus / DoubleRegBus : operand and {remainder, quotient} widths
//   ZeroWord              : all-zero register word
//   DivStart / DivStop    : levels of the divider start line
//   state_t               : issue FSM states (IDLE, BUSY, DONE)
package div_issue_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_issue_if.sv
// div_issue_if: start/annul/operand handshake between the EX-stage issue
// logic (master) and the multi-cycle divider (slave).
//   div_start_o  : keep high to run a divide; dropping it idles the divider
//   div_annul_o  : one-cycle cancel of the running divide
//   div_signed_o : 1 = signed divide
//   div_op1_o    : dividend, held stable for the whole operation
//   div_op2_o    : divisor, held stable for the whole operation
//   div_result_i : {remainder, quotient}, valid while div_ready_i is high
//   div_ready_i  : result available
// Handshake: the master raises div_start_o with operands valid and keeps
// start and operands unchanged until it samples div_ready_i high (or it
// annuls); the slave keeps div_ready_i/div_result_i valid until start drops.
interface div_issue_if;
  import div_issue_pkg::*;

  logic                    div_start_o;
  logic                    div_annul_o;
  logic                    div_signed_o;
  logic [RegBus-1:0]       div_op1_o;
  logic [RegBus-1:0]       div_op2_o;
  logic [DoubleRegBus-1:0] div_result_i;
  logic                    div_ready_i;

  modport master (
    output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    input  div_result_i, div_ready_i
  );

  modport slave (
    input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    output div_result_i, div_ready_i
  );

endinterface

// File: rtl/div_issue.sv
// div_issue: EX-stage initiator for the multi-cycle divider (DIV/DIVU).
// Latches operands on issue, stalls the pipeline while the divide runs,
// cancels it on flush or timeout, and presents HI/LO with a write strobe.
//   clk, rst      : clock, synchronous active-high reset
//   op_valid_i    : DIV/DIVU present in EX;  op_signed_i : 1 = DIV
//   rs_i, rt_i    : dividend, divisor
//   flush_i       : pipeline flush;  hold_i : downstream stall of EX
//   stall_req_o   : stall request;  hi_o/lo_o : remainder/quotient
//   whilo_o       : HI/LO write enable;  err_o : sticky timeout flag
//   div           : divider handshake (master side)
//   dbg_state     : current FSM state
module div_issue
  import div_issue_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic              op_signed_i,
  input  logic [RegBus-1:0] rs_i,
  input  logic [RegBus-1:0] rt_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_req_o,
  output logic [RegBus-1:0] hi_o,
  output logic [RegBus-1:0] lo_o,
  output logic              whilo_o,
  output logic              err_o,
  div_issue_if.master       div,
  output state_t            dbg_state
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RegBus-1:0]  op1_q, op2_q, hi_q, lo_q;
  logic               signed_q;
  logic               err_q;
  logic               latch_op, latch_res, set_err;
  logic               start, annul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op1_q    <= ZeroWord;
      op2_q    <= ZeroWord;
      signed_q <= 1'b0;
      hi_q     <= ZeroWord;
      lo_q     <= ZeroWord;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch_op) begin
        op1_q    <= rs_i;
        op2_q    <= rt_i;
        signed_q <= op_signed_i;
      end
      if (latch_res) begin
        hi_q <= div.div_result_i[DoubleRegBus-1:RegBus];
        lo_q <= div.div_result_i[RegBus-1:0];
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall_req_o = 1'b0;
    start       = DivStop;
    annul       = 1'b0;
    whilo_o     = 1'b0;
    latch_op    = 1'b0;
    latch_res   = 1'b0;
    set_err     = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid_i && !flush_i) begin
          latch_op    = 1'b1;
          start       = DivStart;
          stall_req_o = 1'b1;
          // cnt counts cycles since the issue cycle, so BUSY cycle k sees k
          cnt_n       = CNT_W'(1);
          state_n     = BUSY;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        start       = DivStart;
        cnt_n       = cnt + CNT_W'(1);
        if (flush_i) begin
          annul   = 1'b1;
          start   = DivStop;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (div.div_ready_i) begin
          latch_res = 1'b1;
          cnt_n     = '0;
          state_n   = DONE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          annul   = 1'b1;
          start   = DivStop;
          set_err = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      DONE: begin
        // start stays low here, which returns the divider to idle before
        // any following DIV can issue
        whilo_o = !flush_i;
        if (flush_i || !hold_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands bypass the registers only in the issue cycle.
  assign div.div_start_o  = start;
  assign div.div_annul_o  = annul;
  assign div.div_signed_o = latch_op ? op_signed_i : signed_q;
  assign div.div_op1_o    = latch_op ? rs_i : op1_q;
  assign div.div_op2_o    = latch_op ? rt_i : op2_q;

  assign hi_o      = (state == DONE) ? hi_q : ZeroWord;
  assign lo_o      = (state == DONE) ? lo_q : ZeroWord;
  assign err_o     = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_div_issue.sv
module tb_div_issue;
  import div_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i, op_signed_i, flush_i, hold_i;
  logic [31:0] rs_i, rt_i;
  logic        stall_req_o, whilo_o, err_o;
  logic [31:0] hi_o, lo_o;
  state_t      dbg_state;
  bit          never_ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  div_issue_if dif();

  div_issue #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_signed_i(op_signed_i),
    .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i), .hold_i(hold_i),
    .stall_req_o(stall_req_o), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .err_o(err_o), .div(dif.master), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- divider stub ----------------
  // Result from magnitude division with sign fix-up; ready seen by the
  // initiator at edge 35 after the first start cycle (edge 3 for /0).
  function automatic logic [63:0] stub_div(bit sgn, logic [31:0] a, logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  int stub_cnt;
  always_ff @(posedge clk) begin
    if (rst || dif.div_annul_o || !dif.div_start_o) begin
      stub_cnt         <= 0;
      dif.div_ready_i  <= 1'b0;
      dif.div_result_i <= 64'd0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!never_ready &&
          (stub_cnt + 1 == ((dif.div_op2_o == 0) ? 2 : 34))) begin
        dif.div_ready_i  <= 1'b1;
        dif.div_result_i <= stub_div(dif.div_signed_o, dif.div_op1_o, dif.div_op2_o);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_div(bit sgn, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // ---------------- checker ----------------
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at negedge+1 with the DUT idle.
  task automatic run_div(bit sgn, logic [31:0] a, logic [31:0] b, int hold_n);
    logic [63:0] exp;
    int stalls;
    bit held;
    exp_q.push_back(ref_div(sgn, a, b));
    op_valid_i = 1'b1; op_signed_i = sgn; rs_i = a; rt_i = b;
    #1;
    check("issue_start", dif.div_start_o, 1);
    check("issue_stall", stall_req_o, 1);
    check("issue_op1", dif.div_op1_o, a);
    @(negedge clk);
    op_valid_i = 1'b0; op_signed_i = ~sgn; rs_i = $urandom; rt_i = $urandom;
    #1;
    stalls = 1;
    held = 1'b1;
    for (int i = 0; i < 100 && stall_req_o; i++) begin
      if (dif.div_op1_o !== a || dif.div_op2_o !== b ||
          dif.div_signed_o !== sgn || dif.div_start_o !== 1'b1) held = 1'b0;
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_len", stalls, (b == 0) ? 3 : 35);
    check("ops_held", held, 1);
    exp = exp_q.pop_front();
    check("result", {hi_o, lo_o}, exp);
    check("done_whilo", whilo_o, 1);
    check("done_start", dif.div_start_o, 0);
    for (int i = 0; i < hold_n; i++) begin
      hold_i = 1'b1;
      @(negedge clk);
      #1;
      check("hold_result", {hi_o, lo_o}, exp);
      check("hold_whilo", whilo_o, 1);
      check("hold_stall", stall_req_o, 0);
    end
    hold_i = 1'b0;
    @(negedge clk);
    #1;
    check("end_whilo", whilo_o, 0);
    check("end_hilo", {hi_o, lo_o}, 0);
  endtask

  task automatic run_flush(logic [31:0] a, logic [31:0] b, int flush_at);
    int annuls, writes;
    op_valid_i = 1'b1; op_signed_i = 1'b1; rs_i = a; rt_i = b;
    @(negedge clk);
    op_valid_i = 1'b0;
    #1;
    annuls = dif.div_annul_o ? 1 : 0;
    writes = whilo_o ? 1 : 0;
    for (int i = 1; i < flush_at; i++) begin
      @(negedge clk);
      #1;
      if (dif.div_annul_o) annuls++;
      if (whilo_o) writes++;
    end
    flush_i = 1'b1;
    #1;
    check("flush_annul", dif.div_annul_o, 1);
    check("flush_start", dif.div_start_o, 0);
    if (dif.div_annul_o) annuls++;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_state", dbg_state, IDLE);
    for (int i = 0; i < 40; i++) begin
      if (dif.div_annul_o) annuls++;
      if (whilo_o) writes++;
      @(negedge clk);
      #1;
    end
    check("flush_annul_pulses", annuls, 1);
    check("flush_no_write", writes, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c;
    logic [31:0] a, b;
    bit sgn;
    never_ready = 1'b0;
    op_valid_i = 1'b0; op_signed_i = 1'b0; rs_i = '0; rt_i = '0;
    flush_i = 1'b0; hold_i = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_state", dbg_state, IDLE);
    check("rst_stall", stall_req_o, 0);
    check("rst_whilo", whilo_o, 0);
    check("rst_err", err_o, 0);
    check("rst_hilo", {hi_o, lo_o}, 0);
    check("rst_start_annul", {dif.div_start_o, dif.div_annul_o}, 0);
    check("rst_ops", {dif.div_op1_o, dif.div_op2_o, 31'd0, dif.div_signed_o}, 0);

    run_div(1'b1, 32'd7, 32'd2, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'h1234_5678, 32'd0, 0);
    run_flush(32'd100, 32'd7, 10);
    run_div(1'b1, 32'd9, 32'd3, 0);
    run_div(1'b1, 32'd100, 32'd7, 4);
    run_div(1'b0, 32'd50, 32'd5, 0);

    // request during a flush in IDLE is dropped
    op_valid_i = 1'b1; flush_i = 1'b1; rs_i = 32'd8; rt_i = 32'd2;
    #1;
    check("idle_flush_start", dif.div_start_o, 0);
    check("idle_flush_stall", stall_req_o, 0);
    @(negedge clk);
    op_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check("idle_flush_state", dbg_state, IDLE);

    for (int n = 0; n < 8; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_div(sgn, a, b, $urandom_range(0, 2));
    end

    // reset in the middle of a divide
    op_valid_i = 1'b1; op_signed_i = 1'b1; rs_i = 32'd77; rt_i = 32'd7;
    @(negedge clk);
    op_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", dbg_state, IDLE);
    check("midrst_stall", stall_req_o, 0);
    run_div(1'b1, 32'd77, 32'd7, 0);

    // divider that never answers
    never_ready = 1'b1;
    op_valid_i = 1'b1; op_signed_i = 1'b0; rs_i = 32'd1000; rt_i = 32'd3;
    @(negedge clk);
    op_valid_i = 1'b0;
    #1;
    c = 1;
    while (!dif.div_annul_o && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("timeout_cycle", c, 40);
    check("timeout_whilo", whilo_o, 0);
    @(negedge clk);
    #1;
    check("timeout_err", err_o, 1);
    check("timeout_state", dbg_state, IDLE);
    never_ready = 1'b0;
    run_div(1'b1, 32'd21, 32'd4, 0);
    check("err_sticky", err_o, 1);
    do_reset();
    check("err_cleared", err_o, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
